// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 16-bit register file.
// Shares the single GPR write port among three requesters (0 = ALU, 1 = load,
// 2 = mul/div) using valid/ready handshakes. The winning write is registered
// into an output stage that drives the register file. A per-register pending
// mask is published for the hazard logic.
// Build option: define WB_ARB_RR_EN for round-robin arbitration. Without it,
// arbitration is fixed priority 0 > 1 > 2.
module regfile_wb_arbiter #(
  parameter int DW   = 16,
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [3*NREQ-1:0]  req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wb_hold,
  output logic               rd_write_en,
  output logic [2:0]         rd_addr,
  output logic [DW-1:0]      rd_write_data,
  output logic [7:0]         pending_mask,
  output logic [15:0]        conflict_cnt
);

  logic [NREQ-1:0] grant;
  logic [1:0]      grant_idx;
  logic            handshake;
  logic [2:0]      sel_addr;
  logic [DW-1:0]   sel_data;
  logic [1:0]      valid_cnt;

  logic            rd_write_en_q, rd_write_en_d;
  logic [2:0]      rd_addr_q, rd_addr_d;
  logic [DW-1:0]   rd_write_data_q, rd_write_data_d;
  logic [15:0]     conflict_cnt_q, conflict_cnt_d;

`ifdef WB_ARB_RR_EN
  logic [1:0]      last_grant_q, last_grant_d;

  // Index (base + off) mod 3, with base in 0..2 and off in 1..3.
  function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    grant = '0;
    found = 1'b0;
    cand  = 2'd0;
    if (!reset && !wb_hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = wrap3(last_grant_q, 2'(k));
        if (!found && req_valid[cand]) begin
          grant[cand] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end
`else
  // Fixed priority: lowest requester index wins.
  always_comb begin
    grant = '0;
    if (!reset && !wb_hold) begin
      if (req_valid[0])      grant[0] = 1'b1;
      else if (req_valid[1]) grant[1] = 1'b1;
      else if (req_valid[2]) grant[2] = 1'b1;
    end
  end
`endif

  assign req_ready = grant;

  // Encode the one-hot grant and select the winning address and data.
  always_comb begin
    grant_idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = 2'(i);
    end
    handshake = |(grant & req_valid);
    sel_addr  = req_addr[3*grant_idx +: 3];
    sel_data  = req_data[DW*grant_idx +: DW];
  end

  // Next state of the output stage; index 0 writes are accepted but suppressed.
  always_comb begin
    rd_write_en_d   = 1'b0;
    rd_addr_d       = rd_addr_q;
    rd_write_data_d = rd_write_data_q;
    if (handshake) begin
      rd_write_en_d   = (sel_addr != 3'd0);
      rd_addr_d       = sel_addr;
      rd_write_data_d = sel_data;
    end
  end

`ifdef WB_ARB_RR_EN
  // The round-robin pointer only moves on a completed handshake.
  always_comb begin
    last_grant_d = handshake ? grant_idx : last_grant_q;
  end
`endif

  // Count cycles with two or more competing requests, saturating at all-ones.
  always_comb begin
    valid_cnt = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      valid_cnt = valid_cnt + {1'b0, req_valid[i]};
    end
    conflict_cnt_d = conflict_cnt_q;
    if (valid_cnt >= 2'd2 && !wb_hold && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_write_en_q   <= 1'b0;
      rd_addr_q       <= 3'd0;
      rd_write_data_q <= '0;
      conflict_cnt_q  <= 16'd0;
`ifdef WB_ARB_RR_EN
      last_grant_q    <= 2'd2;
`endif
    end else begin
      rd_write_en_q   <= rd_write_en_d;
      rd_addr_q       <= rd_addr_d;
      rd_write_data_q <= rd_write_data_d;
      conflict_cnt_q  <= conflict_cnt_d;
`ifdef WB_ARB_RR_EN
      last_grant_q    <= last_grant_d;
`endif
    end
  end

  // Pending mask: every requested destination plus the write in flight; GPR 0 never pends.
  always_comb begin
    pending_mask = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) pending_mask[req_addr[3*i +: 3]] = 1'b1;
    end
    if (rd_write_en_q) pending_mask[rd_addr_q] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign rd_write_en   = rd_write_en_q;
  assign rd_addr       = rd_addr_q;
  assign rd_write_data = rd_write_data_q;
  assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
// Expectations follow the round-robin build when WB_ARB_RR_EN is defined and
// the fixed-priority build otherwise.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [8:0]  req_addr;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        wb_hold;
  logic        rd_write_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_write_data;
  logic [7:0]  pending_mask;
  logic [15:0] conflict_cnt;

  int checkCount = 0;
  int failCount  = 0;

  logic [2:0] monUnserved = 3'b000;
  logic       monArmed    = 1'b0;

  regfile_wb_arbiter #(.DW(16), .NREQ(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .wb_hold       (wb_hold),
    .rd_write_en   (rd_write_en),
    .rd_addr       (rd_addr),
    .rd_write_data (rd_write_data),
    .pending_mask  (pending_mask),
    .conflict_cnt  (conflict_cnt)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive all requester inputs at once (inputs change just after the falling edge)
  task automatic applyStimulus(input logic [2:0] valid,
                               input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                               input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                               input logic hold);
    req_valid = valid;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    wb_hold   = hold;
  endtask

  // Advance one clock and land 1 ns after the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Flag a requester that dropped valid without completing its handshake
  always @(negedge clk) begin
    #3;
    if (!reset && monArmed)
      checkOutput("valid_held", 32'(req_valid & monUnserved), 32'(monUnserved));
    monUnserved = reset ? 3'b000 : (req_valid & ~req_ready);
    monArmed    = !reset;
  end

  // Hard bound on total simulation time
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence of tests
  initial begin
    logic [2:0] expReady;
    reset = 1'b1;
    applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    #1;

    // Reset state
    checkOutput("rst_wen", 32'(rd_write_en), 32'h0);
    checkOutput("rst_addr", 32'(rd_addr), 32'h0);
    checkOutput("rst_data", 32'(rd_write_data), 32'h0);
    checkOutput("rst_cnt", 32'(conflict_cnt), 32'h0);
    applyStimulus(3'b001, 3'd5, 3'd0, 3'd0, 16'hBEEF, 16'h0, 16'h0, 1'b0);
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_pend", 32'(pending_mask), 32'h20);
    step();
    reset = 1'b0;
    #1;

    // Single request from requester 0
    checkOutput("single_ready", 32'(req_ready), 32'h1);
    checkOutput("single_pend0", 32'(pending_mask), 32'h20);
    step();
    applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    #1;
    checkOutput("single_wen", 32'(rd_write_en), 32'h1);
    checkOutput("single_addr", 32'(rd_addr), 32'h5);
    checkOutput("single_data", 32'(rd_write_data), 32'hBEEF);
    checkOutput("single_pend1", 32'(pending_mask), 32'h20);
    step();
    checkOutput("idle_wen", 32'(rd_write_en), 32'h0);
    checkOutput("idle_addr_hold", 32'(rd_addr), 32'h5);
    checkOutput("idle_data_hold", 32'(rd_write_data), 32'hBEEF);
    checkOutput("idle_pend", 32'(pending_mask), 32'h00);

    // All three requesters valid continuously, fresh pointer
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(3'b111, 3'd1, 3'd2, 3'd3, 16'h00A1, 16'h00A2, 16'h00A3, 1'b0);
    #1;
    checkOutput("all_pend", 32'(pending_mask), 32'h0E);
    for (int k = 0; k < 6; k++) begin
`ifdef WB_ARB_RR_EN
      expReady = 3'b001 << (k % 3);
`else
      expReady = 3'b001;
`endif
      checkOutput($sformatf("all_ready%0d", k), 32'(req_ready), 32'(expReady));
      step();
`ifdef WB_ARB_RR_EN
      checkOutput($sformatf("all_addr%0d", k), 32'(rd_addr), 32'((k % 3) + 1));
      checkOutput($sformatf("all_data%0d", k), 32'(rd_write_data), 32'(16'h00A1 + (k % 3)));
`else
      checkOutput($sformatf("all_addr%0d", k), 32'(rd_addr), 32'h1);
      checkOutput($sformatf("all_data%0d", k), 32'(rd_write_data), 32'h00A1);
`endif
      checkOutput($sformatf("all_cnt%0d", k), 32'(conflict_cnt), 32'(k + 1));
    end
    reset = 1'b1;
    step();
    applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    #1;

    // Write to GPR 0 by requester 1 is accepted and discarded
    applyStimulus(3'b010, 3'd0, 3'd0, 3'd0, 16'h0, 16'h1234, 16'h0, 1'b0);
    #1;
    checkOutput("zero_ready", 32'(req_ready), 32'h2);
    checkOutput("zero_pend0", 32'(pending_mask), 32'h00);
    step();
    applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    #1;
    checkOutput("zero_wen", 32'(rd_write_en), 32'h0);
    checkOutput("zero_addr", 32'(rd_addr), 32'h0);
    checkOutput("zero_data", 32'(rd_write_data), 32'h1234);
    checkOutput("zero_pend1", 32'(pending_mask), 32'h00);

    // Hold for three cycles with requesters 1 and 2 waiting
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(3'b110, 3'd0, 3'd4, 3'd6, 16'h0, 16'h4444, 16'h6666, 1'b1);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("hold_ready%0d", k), 32'(req_ready), 32'h0);
      checkOutput($sformatf("hold_pend%0d", k), 32'(pending_mask), 32'h50);
      step();
      checkOutput($sformatf("hold_wen%0d", k), 32'(rd_write_en), 32'h0);
    end
    checkOutput("hold_cnt", 32'(conflict_cnt), 32'h0);
    wb_hold = 1'b0;
    #1;
    checkOutput("release_ready", 32'(req_ready), 32'h2);
    step();
    checkOutput("release_wen", 32'(rd_write_en), 32'h1);
    checkOutput("release_addr", 32'(rd_addr), 32'h4);
    checkOutput("release_data", 32'(rd_write_data), 32'h4444);
    checkOutput("release_cnt", 32'(conflict_cnt), 32'h1);
    applyStimulus(3'b100, 3'd0, 3'd4, 3'd6, 16'h0, 16'h4444, 16'h6666, 1'b0);
    #1;
    checkOutput("r2_ready", 32'(req_ready), 32'h4);
    step();
    applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    #1;
    checkOutput("r2_addr", 32'(rd_addr), 32'h6);
    checkOutput("r2_data", 32'(rd_write_data), 32'h6666);
    checkOutput("r2_cnt", 32'(conflict_cnt), 32'h1);

    // Drive the conflict counter up to saturation (starts at 1 here)
    applyStimulus(3'b011, 3'd1, 3'd2, 3'd0, 16'h1111, 16'h2222, 16'h0, 1'b0);
    for (int k = 0; k < 65532; k++) step();
    checkOutput("sat_pre", 32'(conflict_cnt), 32'hFFFD);
    step();
    checkOutput("sat_fffe", 32'(conflict_cnt), 32'hFFFE);
    step();
    checkOutput("sat_ffff", 32'(conflict_cnt), 32'hFFFF);
    step();
    checkOutput("sat_hold", 32'(conflict_cnt), 32'hFFFF);
    checkOutput("sat_wen", 32'(rd_write_en), 32'h1);
    checkOutput("sat_addr", 32'(rd_addr), 32'h1);

    // Reset right after a grant drops the in-flight write immediately
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_wen", 32'(rd_write_en), 32'h0);
    checkOutput("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
    checkOutput("mid_rst_pend", 32'(pending_mask), 32'h06);
    step();
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    checkOutput("post_rst_wen", 32'(rd_write_en), 32'h1);
    checkOutput("post_rst_addr", 32'(rd_addr), 32'h1);
    checkOutput("post_rst_data", 32'(rd_write_data), 32'h1111);
    checkOutput("post_rst_cnt", 32'(conflict_cnt), 32'h1);

    reset = 1'b1;
    step();
    applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 16-bit register file. It shares the single GPR write port (rd_write_en / rd_addr / rd_write_data) among three requesters: ALU result, memory load, and multiply/divide low-word result. Each requester uses a valid/ready handshake. The arbiter registers the winning write into an output stage that drives the register file, and it publishes a per-register pending mask for the hazard logic.

## Interface
Parameters:
- DW, 16, data width of write-back data.
- NREQ, 3, number of requesters; fixed at 3, index 0 = ALU, 1 = load, 2 = mul/div.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  3  per-requester write request; bit i belongs to requester i.
- req_addr  in  9  destination GPR index, 3 bits per requester; requester i uses [3i+2:3i].
- req_data  in  48  write data, DW bits per requester; requester i uses [16i+15:16i].
- req_ready  out  3  grant; a handshake completes when valid[i] and ready[i] are both high on a clock edge.
- wb_hold  in  1  blocks all grants while high (pipeline freeze).
- rd_write_en  out  1  register-file write enable, registered.
- rd_addr  out  3  register-file write index, registered.
- rd_write_data  out  16  register-file write data, registered.
- pending_mask  out  8  bit r is high if GPR r is targeted by any asserted req_valid or by the output stage.
- conflict_cnt  out  16  saturating count of cycles where more than one request was valid and wb_hold was low.

## Operation
- At most one grant per cycle. req_ready is combinational from req_valid, wb_hold and the arbitration pointer; it is one-hot or zero.
- A requester must hold valid, addr and data stable until its handshake completes. Dropping valid without a handshake is illegal; the bench flags it.
- Arbitration with round-robin enabled:
  - Search order starts at (last_grant+1) mod 3.
  - last_grant updates only on a completed handshake.
  - Reset value of last_grant is 2, so requester 0 has top priority first.
- Output stage, on a handshake:
  - rd_addr <= req_addr[i] and rd_write_data <= req_data[i].
  - rd_write_en <= 1 if req_addr[i] != 0; a write to index 0 is accepted and discarded (rd_write_en <= 0).
  - With no handshake, rd_write_en <= 0, and rd_addr / rd_write_data hold their previous values.
- wb_hold high: req_ready = 0, last_grant holds, and the output stage takes no new write (rd_write_en <= 0 next cycle).
- pending_mask is combinational:
  - OR of one-hot(req_addr[i]) over every asserted req_valid[i].
  - Plus one-hot(rd_addr) when rd_write_en is high.
  - Bit 0 is always 0.
- conflict_cnt increments when popcount(req_valid) >= 2 and wb_hold is low. It saturates at 16'hFFFF and never wraps.
- Two requesters may target the same address in successive grants. Writes reach the register file in grant order, so the last grant wins.

## Timing
- Handshake at edge N produces rd_write_en / rd_addr / rd_write_data valid during cycle N+1; the register file captures them at edge N+1. Latency is 1 cycle.
- Sustained throughput is one write per cycle. A requester with continuous valid is served at least once every 3 cycles under round-robin.
- Reset values, applied immediately and asynchronously: rd_write_en = 0, rd_addr = 0, rd_write_data = 0, last_grant = 2, conflict_cnt = 0.
- While reset is high, req_ready = 0 and pending_mask reflects only req_valid.
- Reset asserted mid-operation: any write in the output stage is dropped and the requesters keep their valids. After reset deasserts, arbitration restarts with requester 0 highest.
- wb_hold is sampled in the same cycle as req_valid; there is no hold latency.

## Configuration
- WB_ARB_RR_EN defined: round-robin arbitration as described above.
- WB_ARB_RR_EN undefined: fixed priority 0 > 1 > 2. last_grant is not implemented, and requester 2 may starve under continuous requester-0 traffic.
- All other behaviour is identical in both builds, including conflict_cnt and pending_mask.

## Test plan
- Reset then single request: req_valid=3'b001, addr=5, data=16'hBEEF. Required: req_ready=3'b001. Next cycle rd_write_en=1, rd_addr=5, rd_write_data=16'hBEEF, and pending_mask=8'h20 in both cycles.
- All three valid continuously (addrs 1/2/3), RR build. Required: grant order 0,1,2,0,1,2. conflict_cnt increments every cycle.
- Same stimulus, fixed-priority build. Required: requester 0 granted every cycle, req_ready[2] never high.
- Write to index 0 by requester 1 (data 16'h1234). Required: handshake completes, rd_write_en stays 0 next cycle, pending_mask bit 0 stays 0.
- wb_hold=1 for 3 cycles with req_valid=3'b110. Required: req_ready=0 and rd_write_en=0 throughout. On release, requester 1 is granted first (last_grant=2 after reset).
- Reset asserted the cycle after a grant. Required: rd_write_en=0 immediately. conflict_cnt preloaded near 16'hFFFF saturates rather than wrapping before the reset, and reads 0 after it.
